// File: rtl/mem_access_monitor.sv
// mem_access_monitor
//   Transparent Avalon-MM monitor that sits between the CPU (s_*) and the
//   memory delay-injection stage (m_*). It counts reads and writes and
//   measures per-transaction latency as the CPU sees it: the number of cycles
//   the request is asserted, including the completion cycle. Software reads
//   the results through a small CSR slave.
//
//   Ports
//     clk, reset            clock; asynchronous active-high reset
//     s_*                   CPU-side slave; forwarded to m_* with no added latency
//     m_*                   master toward the delay stage
//     csr_address/read/write/writedata/readdata
//                           register slave; readdata is registered and is
//                           valid the cycle after csr_read
//     irq                   present only when MEM_MON_IRQ_EN is defined
//
//   Register map (word index)
//     0 CTRL     [0] enable rw, [1] clear (write 1, reads 0), [2] irq_en rw
//     1 RD_CNT   2 WR_CNT   3 WAIT_SUM   4 MAX_LAT   5 LAST_LAT   (read-only)
//     6 THRESH   rw, LAT_W bits; 0 disables the over-threshold check
//     7 STATUS   [0] over (sticky, write 1 to clear), [1] busy (read-only)
//
//   Build option: define MEM_MON_IRQ_EN to add the irq port and CTRL[2].
//   Without it, CTRL[2] reads 0 and ignores writes.
//
//   CNT_W sets the width of RD_CNT, WR_CNT and WAIT_SUM. Its default of 32
//   fills the CSR word. All counters saturate at all-ones.
module mem_access_monitor #(
    parameter int ADDR_W = 23,
    parameter int DATA_W = 32,
    parameter int LAT_W  = 16,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] s_address,
    input  logic [3:0]        s_byteenable,
    input  logic              s_chipselect,
    input  logic              s_clken,
    input  logic              s_read,
    input  logic              s_write,
    input  logic [DATA_W-1:0] s_writedata,
    output logic [DATA_W-1:0] s_readdata,
    output logic              s_waitrequest,
    output logic [ADDR_W-1:0] m_address,
    output logic [3:0]        m_byteenable,
    output logic              m_chipselect,
    output logic              m_clken,
    output logic              m_read,
    output logic              m_write,
    output logic [DATA_W-1:0] m_writedata,
    input  logic [DATA_W-1:0] m_readdata,
    input  logic              m_waitrequest,
    input  logic [2:0]        csr_address,
    input  logic              csr_read,
    input  logic              csr_write,
    input  logic [31:0]       csr_writedata,
    output logic [31:0]       csr_readdata
`ifdef MEM_MON_IRQ_EN
    ,
    output logic              irq
`endif
);

    // Pass-through. This path is purely combinational and never gated.
    assign m_address     = s_address;
    assign m_byteenable  = s_byteenable;
    assign m_chipselect  = s_chipselect;
    assign m_clken       = s_clken;
    assign m_read        = s_read;
    assign m_write       = s_write;
    assign m_writedata   = s_writedata;
    assign s_readdata    = m_readdata;
    assign s_waitrequest = m_waitrequest;

    typedef enum logic {IDLE, ACTIVE} state_t;

    localparam int SW = LAT_W + CNT_W + 1;

    state_t             state, state_n;
    logic [LAT_W-1:0]   lat, lat_n;
    logic               rec, rec_n;      // enable latched at the start of the transaction
    logic               typ, typ_n;      // 1 = read
    logic               do_rec, rec_rd;
    logic [LAT_W-1:0]   rec_lat;

    logic               enable;
    logic [LAT_W-1:0]   thresh;
    logic               over, over_n;
    logic [CNT_W-1:0]   rd_cnt, wr_cnt, wait_sum;
    logic [LAT_W-1:0]   max_lat, last_lat;
    logic [SW-1:0]      ws_tmp;
    logic [CNT_W-1:0]   ws_sat;
    logic               irq_en_rd;
    logic [31:0]        rdata;

    wire req  = s_read | s_write;
    wire done = req & ~m_waitrequest;

    wire wr_ctrl   = csr_write && csr_address == 3'd0;
    wire wr_thresh = csr_write && csr_address == 3'd6;
    wire wr_status = csr_write && csr_address == 3'd7;
    wire clear     = wr_ctrl && csr_writedata[1];
    wire unused_wd = ^csr_writedata;

    function automatic logic [LAT_W-1:0] lat_inc(input logic [LAT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // Transaction tracker and record decision
    always_comb begin
        state_n = state;
        lat_n   = lat;
        rec_n   = rec;
        typ_n   = typ;
        do_rec  = 1'b0;
        rec_lat = lat;
        rec_rd  = typ;
        case (state)
            IDLE: begin
                if (req) begin
                    if (done) begin
                        // Zero-wait transaction: recorded in the same cycle.
                        do_rec  = enable;
                        rec_lat = LAT_W'(1);
                        rec_rd  = s_read;
                    end else begin
                        state_n = ACTIVE;
                        lat_n   = LAT_W'(1);
                        rec_n   = enable;
                        typ_n   = s_read;
                    end
                end
            end
            ACTIVE: begin
                if (!req) begin
                    // The master dropped its request mid-stall. The
                    // transaction is discarded.
                    state_n = IDLE;
                end else if (done) begin
                    do_rec  = rec;
                    rec_lat = lat_inc(lat);
                    state_n = IDLE;
                end else begin
                    lat_n = lat_inc(lat);
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Saturating accumulation of wait cycles (lat-1), computed wide enough
    // that the sum cannot wrap before the saturation check.
    always_comb begin
        ws_tmp = SW'(wait_sum) + SW'(rec_lat - 1'b1);
        ws_sat = (ws_tmp > SW'({CNT_W{1'b1}})) ? {CNT_W{1'b1}} : ws_tmp[CNT_W-1:0];
    end

    // A new over-event beats a same-cycle write-1-to-clear. A clear beats both.
    wire over_evt = do_rec && (thresh != '0) && (rec_lat > thresh);
    always_comb begin
        over_n = over;
        if (wr_status && csr_writedata[0]) over_n = 1'b0;
        if (over_evt)                      over_n = 1'b1;
        if (clear)                         over_n = 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            lat      <= '0;
            rec      <= 1'b0;
            typ      <= 1'b0;
            enable   <= 1'b0;
            thresh   <= '0;
            over     <= 1'b0;
            rd_cnt   <= '0;
            wr_cnt   <= '0;
            wait_sum <= '0;
            max_lat  <= '0;
            last_lat <= '0;
        end else begin
            state <= state_n;
            lat   <= lat_n;
            rec   <= rec_n;
            typ   <= typ_n;
            over  <= over_n;
            if (wr_ctrl)   enable <= csr_writedata[0];
            if (wr_thresh) thresh <= csr_writedata[LAT_W-1:0];
            if (clear) begin
                rd_cnt   <= '0;
                wr_cnt   <= '0;
                wait_sum <= '0;
                max_lat  <= '0;
                last_lat <= '0;
            end else if (do_rec) begin
                if (rec_rd) rd_cnt <= cnt_inc(rd_cnt);
                else        wr_cnt <= cnt_inc(wr_cnt);
                wait_sum <= ws_sat;
                last_lat <= rec_lat;
                if (rec_lat > max_lat) max_lat <= rec_lat;
            end
        end
    end

`ifdef MEM_MON_IRQ_EN
    logic irq_en;
    wire  irq_en_n = wr_ctrl ? csr_writedata[2] : irq_en;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            irq_en <= 1'b0;
            irq    <= 1'b0;
        end else begin
            irq_en <= irq_en_n;
            // Built from next-state values so that a w1c of over drops irq
            // on the following cycle.
            irq    <= irq_en_n & over_n;
        end
    end
    assign irq_en_rd = irq_en;
`else
    assign irq_en_rd = 1'b0;
`endif

    always_comb begin
        rdata = '0;
        case (csr_address)
            3'd0: rdata = {29'd0, irq_en_rd, 1'b0, enable};
            3'd1: rdata = 32'(rd_cnt);
            3'd2: rdata = 32'(wr_cnt);
            3'd3: rdata = 32'(wait_sum);
            3'd4: rdata = 32'(max_lat);
            3'd5: rdata = 32'(last_lat);
            3'd6: rdata = 32'(thresh);
            3'd7: rdata = {30'd0, state == ACTIVE, over};
            default: rdata = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)         csr_readdata <= '0;
        else if (csr_read) csr_readdata <= rdata;
    end

endmodule
